// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data_memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 8;
    localparam int REQ0           = 0;
    localparam int REQ1           = 1;
    localparam int MEM_RD_LAT_MAX = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input grant logic with last-grant memory. Define MEM_ARB_FIXED_PRIO_EN
// to make requester 0 win every tie; otherwise ties alternate round-robin.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant_reg;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                gnt = 2'b01;
`else
                // Whoever was not served last wins the tie.
                gnt = last_grant_reg ? 2'b01 : 2'b10;
`endif
            end else begin
                gnt = req;
            end
        end
    end

    // Reset to requester 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant_reg <= 1'b1;
        end else if (|gnt) begin
            last_grant_reg <= gnt[REQ1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data_memory port between two requesters: arbitrates, latches the
// winner's request, sequences memread/memwrite and returns done/read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int CNT_W = $clog2(MEM_RD_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_RD_LAT > 0) ? MEM_RD_LAT - 1 : 0);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              win_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [1:0]        gnt;
    logic [1:0]        done_vec;
    logic [DATA_W-1:0] rdata_vec [2];
    logic              arb_en;
    logic              capture;

    assign arb_en = (state_reg == IDLE) && !RESET;

    rr_arb2 u_arb (
        .clk  (CLK),
        .srst (RESET),
        .req  ({r1_req, r0_req}),
        .en   (arb_en),
        .gnt  (gnt)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|gnt) state_next = ACCESS;
            end
            ACCESS: begin
                if (we_reg) begin
                    state_next = DONE;
                end else if (MEM_RD_LAT == 0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            win_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Request fields are frozen at grant; later input changes are ignored.
            if (|gnt) begin
                win_reg   <= gnt[REQ1];
                we_reg    <= gnt[REQ1] ? r1_we    : r0_we;
                addr_reg  <= gnt[REQ1] ? r1_addr  : r0_addr;
                wdata_reg <= gnt[REQ1] ? r1_wdata : r0_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge CLK) begin
            if (RESET) begin
                rdata_reg <= '0;
            end else if (capture && (win_reg == 1'(gi))) begin
                rdata_reg <= mem_readdata;
            end
        end

        assign rdata_vec[gi] = rdata_reg;
        assign done_vec[gi]  = (state_reg == DONE) && (win_reg == 1'(gi));
    end

    assign r0_gnt   = gnt[REQ0];
    assign r1_gnt   = gnt[REQ1];
    assign r0_done  = done_vec[REQ0];
    assign r1_done  = done_vec[REQ1];
    assign r0_rdata = rdata_vec[REQ0];
    assign r1_rdata = rdata_vec[REQ1];

    assign mem_address   = addr_reg;
    assign mem_writedata = wdata_reg;
    assign mem_memwrite  = (state_reg == ACCESS) && we_reg;
    assign mem_memread   = ((state_reg == ACCESS) && !we_reg) || (state_reg == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance at MEM_RD_LAT=1 with a memory
// model, plus MEM_RD_LAT=0 and 3 instances sharing the request inputs.
module tb_mem_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic       r0_gnt, r0_done, r1_gnt, r1_done;
    logic [7:0] r0_rdata, r1_rdata;
    logic [7:0] mem_address, mem_writedata, mem_readdata;
    logic       mem_memread, mem_memwrite;

    logic [7:0] mem [256];
    logic [7:0] rd_pipe;

    logic       s_r0_gnt [2], s_r0_done [2], s_r1_gnt [2], s_r1_done [2];
    logic       s_rd [2], s_wr [2];
    logic [7:0] s_r0_rdata [2], s_r1_rdata [2], s_addr [2], s_wdata [2], s_rdd [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MEM_RD_LAT(1)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_readdata(mem_readdata)
    );

    // Data becomes valid one edge after the address is presented.
    always @(posedge CLK) begin
        if (mem_memwrite) mem[mem_address] <= mem_writedata;
        rd_pipe <= mem[mem_address];
    end
    assign mem_readdata = rd_pipe;

    for (genvar gi = 0; gi < 2; gi++) begin : g_sw
        mem_arbiter #(.MEM_RD_LAT(gi * 3)) u_sw (
            .CLK(CLK), .RESET(RESET),
            .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
            .r0_gnt(s_r0_gnt[gi]), .r0_done(s_r0_done[gi]), .r0_rdata(s_r0_rdata[gi]),
            .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
            .r1_gnt(s_r1_gnt[gi]), .r1_done(s_r1_done[gi]), .r1_rdata(s_r1_rdata[gi]),
            .mem_address(s_addr[gi]), .mem_writedata(s_wdata[gi]),
            .mem_memread(s_rd[gi]), .mem_memwrite(s_wr[gi]),
            .mem_readdata(s_rdd[gi])
        );
        if (gi == 0) begin : g_l0
            assign s_rdd[gi] = s_addr[gi] ^ 8'h5A;
        end else begin : g_l3
            logic [7:0] p1, p2, p3;
            always @(posedge CLK) begin
                p1 <= s_addr[gi] ^ 8'h5A;
                p2 <= p1;
                p3 <= p2;
            end
            assign s_rdd[gi] = p3;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        smp();
        n_vec++; if (mem_memread !== 1'b0) begin n_miss++; $display("FAIL rst_memread: got %b want 0", mem_memread); end
        n_vec++; if (mem_memwrite !== 1'b0) begin n_miss++; $display("FAIL rst_memwrite: got %b want 0", mem_memwrite); end
        n_vec++; if (mem_address !== 8'h00) begin n_miss++; $display("FAIL rst_addr: got %h want 00", mem_address); end
        n_vec++; if ({r0_gnt, r0_done, r1_gnt, r1_done} !== 4'b0000) begin n_miss++; $display("FAIL rst_handshake: got %b want 0000", {r0_gnt, r0_done, r1_gnt, r1_done}); end
        n_vec++; if (r0_rdata !== 8'h00 || r1_rdata !== 8'h00) begin n_miss++; $display("FAIL rst_rdata: got %h/%h want 00/00", r0_rdata, r1_rdata); end
        tick();
        $display("txn reset released");
    endtask

    task automatic test_write();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h10; r0_wdata = 8'hA5;
        smp();
        n_vec++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin n_miss++; $display("FAIL wr_gnt: got r0=%b r1=%b want r0=1 r1=0", r0_gnt, r1_gnt); end
        tick(); smp();
        n_vec++; if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0) begin n_miss++; $display("FAIL wr_strobe: got we=%b re=%b want we=1 re=0", mem_memwrite, mem_memread); end
        n_vec++; if (mem_address !== 8'h10 || mem_writedata !== 8'hA5) begin n_miss++; $display("FAIL wr_bus: got %h/%h want 10/a5", mem_address, mem_writedata); end
        n_vec++; if (r0_done !== 1'b0) begin n_miss++; $display("FAIL wr_early_done: got %b want 0", r0_done); end
        tick(); r0_req = 1'b0; smp();
        n_vec++; if (r0_done !== 1'b1 || mem_memwrite !== 1'b0) begin n_miss++; $display("FAIL wr_done: got done=%b we=%b want done=1 we=0", r0_done, mem_memwrite); end
        tick();
        $display("txn r0 write addr=10 data=a5");
    endtask

    task automatic test_read_lat1();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
        smp();
        n_vec++; if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin n_miss++; $display("FAIL rd_gnt: got r0=%b r1=%b want r0=0 r1=1", r0_gnt, r1_gnt); end
        tick(); smp();
        n_vec++; if (mem_memread !== 1'b1) begin n_miss++; $display("FAIL rd_memread_c1: got %b want 1", mem_memread); end
        tick(); smp();
        n_vec++; if (mem_memread !== 1'b1 || r1_done !== 1'b0) begin n_miss++; $display("FAIL rd_c2: got re=%b done=%b want re=1 done=0", mem_memread, r1_done); end
        tick(); r1_req = 1'b0; smp();
        n_vec++; if (r1_done !== 1'b1 || r1_rdata !== 8'hA5) begin n_miss++; $display("FAIL rd_done: got done=%b data=%h want done=1 data=a5", r1_done, r1_rdata); end
        n_vec++; if (mem_memread !== 1'b0) begin n_miss++; $display("FAIL rd_memread_done: got %b want 0", mem_memread); end
        n_vec++; if (r0_rdata !== 8'h00) begin n_miss++; $display("FAIL rd_other_rdata: got %h want 00", r0_rdata); end
        tick();
        $display("txn r1 read addr=10 data=%h", r1_rdata);
    endtask

    task automatic test_round_robin();
        logic exp0;
        bit   found;
        RESET = 1'b1; tick(); tick(); RESET = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 8; c++) begin
                smp();
                if (r0_gnt || r1_gnt) begin found = 1'b1; break; end
                tick();
            end
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            n_vec++;
            if (!found || r0_gnt !== exp0 || r1_gnt !== !exp0) begin
                n_miss++;
                $display("FAIL rr_grant%0d: got found=%b r0=%b r1=%b want r0=%b r1=%b", k, found, r0_gnt, r1_gnt, exp0, !exp0);
            end
            $display("txn both-read grant %0d to r%0d", k, r1_gnt);
            tick();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (3) tick();
        smp();
        n_vec++; if (r0_rdata !== 8'hA5 || r1_rdata !== 8'hA5) begin n_miss++; $display("FAIL rr_rdata: got %h/%h want a5/a5", r0_rdata, r1_rdata); end
        tick();
    endtask

    task automatic test_addr_hold();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h20; r0_wdata = 8'h77;
        tick(); r0_req = 1'b0;
        tick(); tick();
        $display("txn r0 write addr=20 data=77");
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
        smp();
        n_vec++; if (r0_gnt !== 1'b1) begin n_miss++; $display("FAIL hold_gnt: got %b want 1", r0_gnt); end
        tick(); tick();
        r0_addr = 8'h20; r0_req = 1'b0;
        smp();
        n_vec++; if (mem_address !== 8'h10 || mem_memread !== 1'b1) begin n_miss++; $display("FAIL hold_addr: got addr=%h re=%b want addr=10 re=1", mem_address, mem_memread); end
        tick(); smp();
        n_vec++; if (r0_done !== 1'b1 || r0_rdata !== 8'hA5) begin n_miss++; $display("FAIL hold_done: got done=%b data=%h want done=1 data=a5", r0_done, r0_rdata); end
        tick();
        $display("txn r0 read addr=10 with input change data=%h", r0_rdata);
    endtask

    task automatic test_reset_mid();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h20;
        smp();
        n_vec++; if (r1_gnt !== 1'b1) begin n_miss++; $display("FAIL rm_gnt: got %b want 1", r1_gnt); end
        tick(); tick();
        RESET = 1'b1; r1_req = 1'b0;
        smp();
        n_vec++; if (mem_memread !== 1'b1) begin n_miss++; $display("FAIL rm_wait: got %b want 1", mem_memread); end
        tick(); smp();
        n_vec++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin n_miss++; $display("FAIL rm_strobes: got re=%b we=%b want 0/0", mem_memread, mem_memwrite); end
        n_vec++; if (r1_done !== 1'b0) begin n_miss++; $display("FAIL rm_no_done: got %b want 0", r1_done); end
        n_vec++; if (r1_rdata !== 8'h00 || r0_rdata !== 8'h00) begin n_miss++; $display("FAIL rm_rdata_clr: got %h/%h want 00/00", r0_rdata, r1_rdata); end
        tick(); RESET = 1'b0;
        r1_req = 1'b1;
        smp();
        n_vec++; if (r1_done !== 1'b0 || r1_gnt !== 1'b1) begin n_miss++; $display("FAIL rm_idle: got done=%b gnt=%b want done=0 gnt=1", r1_done, r1_gnt); end
        tick(); r1_req = 1'b0;
        tick(); tick(); smp();
        n_vec++; if (r1_done !== 1'b1 || r1_rdata !== 8'h77) begin n_miss++; $display("FAIL rm_retry: got done=%b data=%h want done=1 data=77", r1_done, r1_rdata); end
        tick();
        $display("txn r1 read aborted by reset, retried data=%h", r1_rdata);
    endtask

    task automatic test_lat_sweep();
        int lat;
        RESET = 1'b1; tick(); tick(); RESET = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h33;
        for (int c = 0; c < 6; c++) begin
            smp();
            for (int i = 0; i < 2; i++) begin
                lat = i * 3;
                n_vec++;
                if (s_r0_done[i] !== (c == 2 + lat)) begin n_miss++; $display("FAIL lat%0d_done_c%0d: got %b want %b", lat, c, s_r0_done[i], (c == 2 + lat)); end
                if (c == 1) begin
                    n_vec++; if (s_rd[i] !== 1'b1) begin n_miss++; $display("FAIL lat%0d_memread_c1: got %b want 1", lat, s_rd[i]); end
                end
                if (c == 2 + lat) begin
                    n_vec++; if (s_rd[i] !== 1'b0) begin n_miss++; $display("FAIL lat%0d_memread_done: got %b want 0", lat, s_rd[i]); end
                    n_vec++; if (s_r0_rdata[i] !== 8'h69) begin n_miss++; $display("FAIL lat%0d_rdata: got %h want 69", lat, s_r0_rdata[i]); end
                end
            end
            tick();
            if (c == 0) r0_req = 1'b0;
        end
        $display("txn r0 read addr=33 lat0 data=%h lat3 data=%h", s_r0_rdata[0], s_r0_rdata[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        RESET = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
        test_reset();
        test_write();
        test_read_lat1();
        test_round_robin();
        test_addr_hold();
        test_reset_mid();
        test_lat_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
